// File: rtl/spi_req_sequencer.sv
// Shares one SPI master engine between a configuration requester (A) and a status
// poller (B): round-robin grant, slave-select framing, engine handshake and watchdog.
module spi_req_sequencer #(
    parameter int unsigned DAT_WIDTH = 3,
    parameter int unsigned CS_SETUP  = 4,
    parameter int unsigned CS_HOLD   = 4,
    parameter int unsigned CS_GAP    = 2,
    parameter int unsigned TMO_W     = 12
) (
    input  logic                   clk,
    input  logic                   asyncRst,
    input  logic                   reqA,
    input  logic [DAT_WIDTH*8-1:0] datA,
    output logic                   ackA,
    input  logic                   reqB,
    input  logic [DAT_WIDTH*8-1:0] datB,
    output logic                   ackB,
    output logic [DAT_WIDTH*8-1:0] rdDat,
    output logic                   err,
    output logic                   busy,
    output logic                   ssN,
    output logic                   spiWrEn,
    output logic [DAT_WIDTH*8-1:0] spiData,
    input  logic                   spiRdy,
    input  logic [DAT_WIDTH*8-1:0] spiDatBack
);

    localparam int unsigned DW       = DAT_WIDTH * 8;
    localparam int unsigned CS_MAX_A = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
    localparam int unsigned CS_MAX   = (CS_MAX_A > CS_GAP) ? CS_MAX_A : CS_GAP;
    localparam int unsigned CNT_W    = $clog2(CS_MAX) + 1;
    // Watchdog fires on the WAIT cycle in which the counter would reach all-ones.
    localparam logic [TMO_W-1:0] WDOG_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, ARM, WAIT, HOLD, GAP} state_t;

    state_t           state, stateNxt;
    logic [CNT_W-1:0] cnt, cntNxt;
    logic [TMO_W-1:0] wdog, wdogNxt;
    logic             grantB, grantBNxt;
    logic             lastB, lastBNxt;
    logic             tmo, tmoNxt;
    logic             ssNNxt, spiWrEnNxt, ackANxt, ackBNxt, errNxt;
    logic [DW-1:0]    spiDataNxt, rdDatNxt;

    // State and registered outputs.
    always_ff @(posedge clk or posedge asyncRst) begin
        if (asyncRst) begin
            state   <= IDLE;
            cnt     <= '0;
            wdog    <= '0;
            grantB  <= 1'b0;
            lastB   <= 1'b1;
            tmo     <= 1'b0;
            ssN     <= 1'b1;
            spiWrEn <= 1'b0;
            spiData <= '0;
            ackA    <= 1'b0;
            ackB    <= 1'b0;
            rdDat   <= '0;
            err     <= 1'b0;
            busy    <= 1'b0;
        end else begin
            state   <= stateNxt;
            cnt     <= cntNxt;
            wdog    <= wdogNxt;
            grantB  <= grantBNxt;
            lastB   <= lastBNxt;
            tmo     <= tmoNxt;
            ssN     <= ssNNxt;
            spiWrEn <= spiWrEnNxt;
            spiData <= spiDataNxt;
            ackA    <= ackANxt;
            ackB    <= ackBNxt;
            rdDat   <= rdDatNxt;
            err     <= errNxt;
            busy    <= (stateNxt != IDLE);
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        stateNxt   = state;
        cntNxt     = cnt;
        wdogNxt    = wdog;
        grantBNxt  = grantB;
        lastBNxt   = lastB;
        tmoNxt     = tmo;
        ssNNxt     = ssN;
        spiWrEnNxt = 1'b0;
        spiDataNxt = spiData;
        ackANxt    = 1'b0;
        ackBNxt    = 1'b0;
        rdDatNxt   = rdDat;
        errNxt     = 1'b0;

        case (state)
            IDLE: begin
                if (reqA || reqB) begin
                    stateNxt   = SETUP;
                    grantBNxt  = reqB && (!reqA || !lastB);
                    spiDataNxt = grantBNxt ? datB : datA;
                    ssNNxt     = 1'b0;
                    cntNxt     = '0;
                end
            end
            SETUP: begin
                if (cnt == CNT_W'(CS_SETUP - 1)) begin
                    stateNxt   = STROBE;
                    spiWrEnNxt = 1'b1;
                    cntNxt     = '0;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            STROBE: stateNxt = ARM;
            // Engine ready is still stale here; skip it.
            ARM: begin
                stateNxt = WAIT;
                wdogNxt  = '0;
                tmoNxt   = 1'b0;
            end
            WAIT: begin
                if (spiRdy) begin
                    rdDatNxt = spiDatBack;
                    stateNxt = HOLD;
                    cntNxt   = '0;
                end else if (wdog == WDOG_LAST) begin
                    tmoNxt   = 1'b1;
                    stateNxt = HOLD;
                    cntNxt   = '0;
                end else begin
                    wdogNxt = wdog + TMO_W'(1);
                end
            end
            HOLD: begin
                if (cnt == CNT_W'(CS_HOLD - 1)) begin
                    stateNxt = GAP;
                    ssNNxt   = 1'b1;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            GAP: begin
                if (cnt == CNT_W'(CS_GAP - 1)) begin
                    stateNxt = IDLE;
                    cntNxt   = '0;
                end else begin
                    cntNxt = cnt + CNT_W'(1);
                end
            end
            default: stateNxt = IDLE;
        endcase

        // Ack lands in the final HOLD cycle, while ssN is still low.
        if (stateNxt == HOLD && cntNxt == CNT_W'(CS_HOLD - 1)) begin
            ackANxt  = !grantBNxt;
            ackBNxt  = grantBNxt;
            errNxt   = tmoNxt;
            lastBNxt = grantBNxt;
        end
    end

endmodule

// File: tb/tb_spi_req_sequencer.sv
// Bench for spi_req_sequencer: behavioural SPI engine, ack scoreboard, vector table
// and hand-written sequences for contention, timeout and asynchronous reset.
module tb_spi_req_sequencer;

    localparam int unsigned CS_SETUP = 4;
    localparam int unsigned CS_HOLD  = 4;
    localparam int unsigned CS_GAP   = 2;
    localparam int unsigned TMO_MAX  = 4095;
    localparam logic [23:0] ECHO_KEY = 24'h5A5A5A;

    logic        clk = 1'b0;
    logic        asyncRst;
    logic        reqA, reqB;
    logic [23:0] datA, datB;
    logic        ackA, ackB;
    logic [23:0] rdDat;
    logic        err, busy, ssN, spiWrEn;
    logic [23:0] spiData;
    logic        spiRdy;
    logic [23:0] spiDatBack;

    spi_req_sequencer dut (
        .clk(clk), .asyncRst(asyncRst),
        .reqA(reqA), .datA(datA), .ackA(ackA),
        .reqB(reqB), .datB(datB), .ackB(ackB),
        .rdDat(rdDat), .err(err), .busy(busy), .ssN(ssN),
        .spiWrEn(spiWrEn), .spiData(spiData),
        .spiRdy(spiRdy), .spiDatBack(spiDatBack)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Engine model: ready drops after the strobe (or one cycle late), returns engN cycles after ARM.
    int          engN = 5;
    bit          engNever = 0, engLate = 0, engEcho = 1;
    logic [23:0] engResp = '0;
    logic [23:0] txLatched;
    bit          pending;
    int          armCnt;

    always @(posedge clk or posedge asyncRst) begin
        if (asyncRst) begin
            spiRdy     <= 1'b1;
            spiDatBack <= '0;
            pending    <= 1'b0;
            armCnt     <= 0;
            txLatched  <= '0;
        end else if (spiWrEn) begin
            pending    <= 1'b1;
            armCnt     <= 0;
            spiRdy     <= engLate;
            spiDatBack <= 24'hBAD0BA;
            txLatched  <= spiData;
        end else if (pending) begin
            armCnt <= armCnt + 1;
            if (engLate && armCnt == 0) spiRdy <= 1'b0;
            if (!engNever && armCnt + 1 == engN) begin
                spiRdy     <= 1'b1;
                spiDatBack <= engEcho ? (txLatched ^ ECHO_KEY) : engResp;
                pending    <= 1'b0;
            end
        end
    end

    typedef struct {
        bit          isB;
        logic [23:0] tx;
        logic [23:0] rd;
        bit          err;
    } exp_t;

    exp_t        sbq[$];
    logic [23:0] modelRd = '0;

    task automatic push(input bit isB, input logic [23:0] tx, input logic [23:0] rd, input bit e);
        exp_t x;
        x.isB = isB; x.tx = tx; x.rd = rd; x.err = e;
        sbq.push_back(x);
        if (!e) modelRd = rd;
    endtask

    // Frame monitor and scoreboard consumer, sampled on the falling edge.
    int          highRun = 0, setupRun = 0;
    bit          haveFrame = 0, strobed = 0;
    logic [23:0] txSeen = '0;

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (asyncRst) begin
                highRun = 0; setupRun = 0; haveFrame = 0; strobed = 0;
            end else begin
                if (spiWrEn) begin
                    check(ssN == 1'b0, "wr_while_ss_high", 32'(ssN), 32'd0);
                    check(setupRun == int'(CS_SETUP), "setup_len", 32'(setupRun), 32'(CS_SETUP));
                    strobed = 1;
                    txSeen  = spiData;
                end
                if (ssN) begin
                    highRun++;
                    strobed  = 0;
                    setupRun = 0;
                end else begin
                    if (haveFrame && highRun > 0)
                        check(highRun >= int'(CS_GAP), "gap_len", 32'(highRun), 32'(CS_GAP));
                    haveFrame = 1;
                    highRun   = 0;
                    if (!strobed && !spiWrEn) setupRun++;
                end
                if (ackA || ackB) begin
                    check(!(ackA && ackB), "dual_ack", {30'd0, ackA, ackB}, 32'd0);
                    check(sbq.size() != 0, "unexpected_ack", 32'(sbq.size()), 32'd1);
                    if (sbq.size() != 0) begin
                        e = sbq.pop_front();
                        check(ackB == e.isB, "ack_grant", 32'(ackB), 32'(e.isB));
                        check(txSeen == e.tx, "tx_word", 32'(txSeen), 32'(e.tx));
                        check(rdDat == e.rd, "rd_word", 32'(rdDat), 32'(e.rd));
                        check(err == e.err, "err_flag", 32'(err), 32'(e.err));
                        check(ssN == 1'b0, "ack_in_hold", 32'(ssN), 32'd0);
                    end
                end
            end
        end
    end

    task automatic waitAck(input int bound, output int lat);
        lat = 0;
        forever begin
            @(posedge clk);
            #1;
            lat++;
            if (ackA || ackB) break;
            if (lat > bound) begin
                check(1'b0, "ack_timeout", 32'(lat), 32'(bound));
                break;
            end
        end
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check(busy == 1'b0, "idle_timeout", 32'(busy), 32'd0);
    endtask

    typedef struct {
        bit          rA, rB;
        logic [23:0] dA, dB, resp;
        int          n;
        bit          never, late, expB, expErr;
    } vec_t;

    function automatic vec_t mk(input bit rA, input bit rB, input logic [23:0] dA, input logic [23:0] dB,
                                input logic [23:0] resp, input int n, input bit never, input bit late,
                                input bit expB, input bit expErr);
        vec_t v;
        v.rA = rA; v.rB = rB; v.dA = dA; v.dB = dB; v.resp = resp; v.n = n;
        v.never = never; v.late = late; v.expB = expB; v.expErr = expErr;
        return v;
    endfunction

    task automatic runVector(input vec_t v, input int idx);
        int lat, effN;
        waitIdle();
        engN = v.n; engNever = v.never; engLate = v.late; engEcho = 0; engResp = v.resp;
        push(v.expB, v.expB ? v.dB : v.dA, v.expErr ? modelRd : v.resp, v.expErr);
        datA = v.dA; datB = v.dB; reqA = v.rA; reqB = v.rB;
        waitAck(6000, lat);
        effN = v.never ? int'(TMO_MAX) : v.n;
        check(lat == int'(CS_SETUP + CS_HOLD) + 2 + effN, $sformatf("latency_v%0d", idx),
              32'(lat), 32'(int'(CS_SETUP + CS_HOLD) + 2 + effN));
        @(negedge clk);
        reqA = 1'b0; reqB = 1'b0;
    endtask

    vec_t vecs[8];

    initial begin
        int lat, n;
        vecs[0] = mk(1, 0, 24'hA5C3F0, 24'h000000, 24'h123456, 50, 0, 0, 0, 0);
        vecs[1] = mk(1, 1, 24'h0A0B0C, 24'hB0B1B2, 24'h654321, 3, 0, 0, 1, 0);
        vecs[2] = mk(1, 1, 24'hA1A2A3, 24'hB3B4B5, 24'h00FF00, 1, 0, 0, 0, 0);
        vecs[3] = mk(1, 1, 24'hC0FFEE, 24'hFACADE, 24'h800001, 7, 0, 0, 1, 0);
        vecs[4] = mk(0, 1, 24'h111111, 24'h7E57ED, 24'h0F0F0F, 2, 0, 0, 1, 0);
        vecs[5] = mk(1, 1, 24'h5EED00, 24'h999999, 24'hABCDEF, 4, 0, 0, 0, 0);
        vecs[6] = mk(1, 0, 24'h7777AA, 24'h000000, 24'hEEEEEE, 1, 1, 0, 0, 1);
        vecs[7] = mk(0, 1, 24'h000000, 24'h4C4A7E, 24'h13579B, 3, 0, 1, 1, 0);

        asyncRst = 1'b1;
        reqA = 1'b1; reqB = 1'b1;
        datA = 24'h111111; datB = 24'h222222;
        #12;
        check(ssN == 1'b1, "rst_ssN", 32'(ssN), 32'd1);
        check(spiWrEn == 1'b0, "rst_spiWrEn", 32'(spiWrEn), 32'd0);
        check(spiData == 24'd0, "rst_spiData", 32'(spiData), 32'd0);
        check(ackA == 1'b0, "rst_ackA", 32'(ackA), 32'd0);
        check(ackB == 1'b0, "rst_ackB", 32'(ackB), 32'd0);
        check(rdDat == 24'd0, "rst_rdDat", 32'(rdDat), 32'd0);
        check(err == 1'b0, "rst_err", 32'(err), 32'd0);
        check(busy == 1'b0, "rst_busy", 32'(busy), 32'd0);

        // Both requesters held from reset: grants alternate, A first.
        engN = 5; engEcho = 1;
        push(0, 24'h111111, 24'h111111 ^ ECHO_KEY, 0);
        push(1, 24'h222222, 24'h222222 ^ ECHO_KEY, 0);
        push(0, 24'h111111, 24'h111111 ^ ECHO_KEY, 0);
        push(1, 24'h222222, 24'h222222 ^ ECHO_KEY, 0);
        @(negedge clk);
        asyncRst = 1'b0;
        for (int i = 0; i < 4; i++) waitAck(200, lat);
        @(negedge clk);
        reqA = 1'b0; reqB = 1'b0;

        for (int i = 0; i < 8; i++) runVector(vecs[i], i);

        // B raised mid-way through an A frame waits for A's gap.
        waitIdle();
        engN = 8; engNever = 0; engLate = 0; engEcho = 1;
        datA = 24'h3C3C3C; datB = 24'hC3C3C3;
        push(0, 24'h3C3C3C, 24'h3C3C3C ^ ECHO_KEY, 0);
        push(1, 24'hC3C3C3, 24'hC3C3C3 ^ ECHO_KEY, 0);
        reqA = 1'b1;
        repeat (3) @(negedge clk);
        reqB = 1'b1;
        waitAck(200, lat);
        @(negedge clk);
        reqA = 1'b0;
        waitAck(200, lat);
        @(negedge clk);
        reqB = 1'b0;

        // Asynchronous reset during WAIT, then a clean frame.
        waitIdle();
        engNever = 1;
        datA = 24'h0DDBA1;
        reqA = 1'b1;
        n = 0;
        while (!spiWrEn && n < 50) begin
            @(negedge clk);
            n++;
        end
        check(spiWrEn == 1'b1, "strobe_seen", 32'(spiWrEn), 32'd1);
        repeat (20) @(negedge clk);
        #1 asyncRst = 1'b1;
        #1;
        check(ssN == 1'b1, "arst_ssN", 32'(ssN), 32'd1);
        check(busy == 1'b0, "arst_busy", 32'(busy), 32'd0);
        check(spiWrEn == 1'b0, "arst_spiWrEn", 32'(spiWrEn), 32'd0);
        check(spiData == 24'd0, "arst_spiData", 32'(spiData), 32'd0);
        check(rdDat == 24'd0, "arst_rdDat", 32'(rdDat), 32'd0);
        reqA = 1'b0;
        modelRd = '0;
        repeat (2) @(negedge clk);
        asyncRst = 1'b0;
        runVector(mk(1, 0, 24'h2468AC, 24'h000000, 24'hFEDCBA, 6, 0, 0, 0, 0), 8);

        waitIdle();
        repeat (3) @(negedge clk);
        check(sbq.size() == 0, "sb_leftover", 32'(sbq.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
